// File: rtl/i2c_register_mc_pkg.sv
// i2c_reg_pkg: register map, response codes, FSM states and decode helpers
package i2c_reg_pkg;
  localparam logic [4:0] SREG_REV   = 5'd0;
  localparam logic [4:0] SREG_IDLE  = 5'd1;
  localparam logic [4:0] SREG_FAULT = 5'd2;
  localparam logic [4:0] SREG_RSVD  = 5'd3;
  localparam logic [2:0] CREG_DEV = 3'd0;
  localparam logic [2:0] CREG_REG = 3'd1;
  localparam logic [2:0] CREG_TX  = 3'd2;
  localparam logic [2:0] CREG_CMD = 3'd3;
  localparam logic [2:0] CREG_RX  = 3'd4;
  localparam int CHAN_BASE   = 4;
  localparam int CHAN_STRIDE = 5;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;
  localparam int CMD_LEN_LSB = 0;
  localparam int CMD_LEN_MSB = 2;
  localparam int CMD_WR_BIT  = 4;
  typedef enum logic [1:0] {WS_RST, WS_ACC, WS_EXEC, WS_RESP} wr_state_t;
  typedef enum logic [1:0] {RS_RST, RS_ACC, RS_RESP} rd_state_t;
  typedef struct packed {
    logic       hit;
    logic [2:0] ch;
    logic [2:0] off;
  } chan_sel_t;
  // Maps a register index onto (channel, offset) when it lies inside a channel bank.
  function automatic chan_sel_t chan_decode(input logic [4:0] idx, input int n);
    chan_sel_t r;
    int i;
    int base;
    r = '0;
    i = int'(idx);
    for (int c = 0; c < 7; c++) begin
      base = CHAN_BASE + c * CHAN_STRIDE;
      if (c < n && i >= base && i < base + CHAN_STRIDE) begin
        r.hit = 1'b1;
        r.ch  = 3'(c);
        r.off = 3'(i - base);
      end
    end
    return r;
  endfunction
  // Replaces only the bytes enabled in strb.
  function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction
endpackage

// File: rtl/i2c_register_mc_if.sv
// i2c_register_mc_if: AXI4-Lite bus bundle with master/slave views
interface i2c_register_mc_if;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/i2c_register_mc_axil_port.sv
// i2c_axil_port: AXI4-Lite handshake FSMs producing one-cycle register requests
module i2c_axil_port
  import i2c_reg_pkg::*;
#(
  parameter logic [6:0] ADDR_MASK = 7'h7F
) (
  input  logic          clk,
  input  logic          resetn,
  i2c_register_mc_if.slave axi,
  output logic          wr_req,
  output logic [4:0]    wr_idx,
  output logic [31:0]   wr_data,
  output logic [3:0]    wr_strb,
  input  logic [1:0]    wr_resp,
  output logic [4:0]    rd_idx,
  input  logic [31:0]   rd_data,
  input  logic [1:0]    rd_resp
);
  wr_state_t wstate;
  rd_state_t rstate;
  logic have_aw, have_w, aw_hs, w_hs;
  logic [6:0] aw_m, ar_m;
  logic unused_addr;
  assign aw_m = axi.awaddr[6:0] & ADDR_MASK;
  assign ar_m = axi.araddr[6:0] & ADDR_MASK;
  assign rd_idx = ar_m[6:2];
  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs = axi.wvalid && axi.wready;
  assign unused_addr = ^{axi.awaddr[31:7], axi.araddr[31:7], aw_m[1:0], ar_m[1:0]};
  // Write path: collect AW and W in any order, issue one request, hold B until taken.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wstate <= WS_RST;
      axi.awready <= 1'b0;
      axi.wready <= 1'b0;
      axi.bvalid <= 1'b0;
      axi.bresp <= RESP_OKAY;
      have_aw <= 1'b0;
      have_w <= 1'b0;
      wr_req <= 1'b0;
      wr_idx <= '0;
      wr_data <= '0;
      wr_strb <= '0;
    end else begin
      case (wstate)
        WS_RST: begin
          axi.awready <= 1'b1;
          axi.wready <= 1'b1;
          wstate <= WS_ACC;
        end
        WS_ACC: begin
          if (aw_hs) begin
            axi.awready <= 1'b0;
            have_aw <= 1'b1;
            wr_idx <= aw_m[6:2];
          end
          if (w_hs) begin
            axi.wready <= 1'b0;
            have_w <= 1'b1;
            wr_data <= axi.wdata;
            wr_strb <= axi.wstrb;
          end
          if ((have_aw || aw_hs) && (have_w || w_hs)) begin
            wr_req <= 1'b1;
            wstate <= WS_EXEC;
          end
        end
        WS_EXEC: begin
          wr_req <= 1'b0;
          have_aw <= 1'b0;
          have_w <= 1'b0;
          axi.bvalid <= 1'b1;
          axi.bresp <= wr_resp;
          wstate <= WS_RESP;
        end
        WS_RESP:
          if (axi.bready) begin
            axi.bvalid <= 1'b0;
            axi.awready <= 1'b1;
            axi.wready <= 1'b1;
            wstate <= WS_ACC;
          end
      endcase
    end
  // Read path: register the core's combinational answer on the AR handshake.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rstate <= RS_RST;
      axi.arready <= 1'b0;
      axi.rvalid <= 1'b0;
      axi.rdata <= '0;
      axi.rresp <= RESP_OKAY;
    end else begin
      case (rstate)
        RS_RST: begin
          axi.arready <= 1'b1;
          rstate <= RS_ACC;
        end
        RS_ACC:
          if (axi.arvalid) begin
            axi.arready <= 1'b0;
            axi.rvalid <= 1'b1;
            axi.rdata <= rd_data;
            axi.rresp <= rd_resp;
            rstate <= RS_RESP;
          end
        RS_RESP:
          if (axi.rready) begin
            axi.rvalid <= 1'b0;
            axi.arready <= 1'b1;
            rstate <= RS_ACC;
          end
        default: rstate <= RS_RST;
      endcase
    end
endmodule

// File: rtl/i2c_register_mc.sv
// i2c_register_mc: multi-channel AXI4-Lite control/status banks for I2C engines
module i2c_register_mc
  import i2c_reg_pkg::*;
#(
  parameter int         CHANNELS  = 4,
  parameter int         MAX_LEN   = 4,
  parameter logic [6:0] ADDR_MASK = 7'h7F
) (
  input  logic                    clk,
  input  logic                    resetn,
  i2c_register_mc_if.slave        s_axi,
  output logic [7*CHANNELS-1:0]   o_dev_addr,
  output logic [8*CHANNELS-1:0]   o_reg_num,
  output logic [3*CHANNELS-1:0]   o_len,
  output logic [CHANNELS-1:0]     o_wr,
  output logic [32*CHANNELS-1:0]  o_tx_data,
  output logic [CHANNELS-1:0]     o_start,
  input  logic [CHANNELS-1:0]     i_idle,
  input  logic [CHANNELS-1:0]     i_fault,
  input  logic [32*CHANNELS-1:0]  i_rx_data,
  input  logic [31:0]             i_module_rev
);
  logic wr_req;
  logic [4:0] wr_idx, rd_idx;
  logic [31:0] wr_data, rd_data;
  logic [3:0] wr_strb;
  logic [1:0] wr_resp, rd_resp;
  logic [31:0] dev_addr [CHANNELS];
  logic [31:0] reg_num [CHANNELS];
  logic [31:0] tx_data [CHANNELS];
  logic [2:0] len [CHANNELS];
  logic [CHANNELS-1:0] wr, start, fault, fault_q, fault_clr, we_dev, we_reg, we_tx, we_cmd;
  logic [2:0] cmd_len;
  chan_sel_t ws, rs;
  i2c_axil_port #(.ADDR_MASK(ADDR_MASK)) u_port (
    .clk(clk),
    .resetn(resetn),
    .axi(s_axi),
    .wr_req(wr_req),
    .wr_idx(wr_idx),
    .wr_data(wr_data),
    .wr_strb(wr_strb),
    .wr_resp(wr_resp),
    .rd_idx(rd_idx),
    .rd_data(rd_data),
    .rd_resp(rd_resp)
  );
  assign ws = chan_decode(wr_idx, CHANNELS);
  assign rs = chan_decode(rd_idx, CHANNELS);
  assign cmd_len = wr_data[CMD_LEN_MSB:CMD_LEN_LSB];
  // Write decode: busy interlock and length check gate every channel-bank side effect.
  always_comb begin
    wr_resp = RESP_OKAY;
    fault_clr = '0;
    we_dev = '0;
    we_reg = '0;
    we_tx = '0;
    we_cmd = '0;
    if (ws.hit) begin
      for (int c = 0; c < CHANNELS; c++)
        if (ws.ch == 3'(c)) begin
          if (ws.off == CREG_RX || !i_idle[c]) wr_resp = RESP_SLVERR;
          else if (ws.off == CREG_CMD) begin
            if (wr_strb[0]) begin
              if (cmd_len == 3'd0 || cmd_len > 3'(MAX_LEN)) wr_resp = RESP_SLVERR;
              else we_cmd[c] = wr_req;
            end
          end else begin
            we_dev[c] = wr_req && ws.off == CREG_DEV;
            we_reg[c] = wr_req && ws.off == CREG_REG;
            we_tx[c] = wr_req && ws.off == CREG_TX;
          end
        end
    end else if (wr_idx == SREG_FAULT)
      fault_clr = (wr_req && wr_strb[0]) ? wr_data[CHANNELS-1:0] : '0;
    else
      wr_resp = RESP_SLVERR;
  end
  // Read decode: indices past the last channel bank answer DECERR with zero data.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (rs.hit) begin
      for (int c = 0; c < CHANNELS; c++)
        if (rs.ch == 3'(c))
          rd_data = rs.off == CREG_DEV ? dev_addr[c] :
                    rs.off == CREG_REG ? reg_num[c] :
                    rs.off == CREG_TX  ? tx_data[c] :
                    rs.off == CREG_RX  ? i_rx_data[32*c +: 32] : '0;
    end else if (rd_idx == SREG_REV) rd_data = i_module_rev;
    else if (rd_idx == SREG_IDLE) rd_data = 32'(i_idle);
    else if (rd_idx == SREG_FAULT) rd_data = 32'(fault);
    else if (rd_idx != SREG_RSVD) rd_resp = RESP_DECERR;
  end
  // Register state; a new fault edge wins over a same-cycle W1C clear.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      for (int c = 0; c < CHANNELS; c++) begin
        dev_addr[c] <= '0;
        reg_num[c] <= '0;
        tx_data[c] <= '0;
        len[c] <= '0;
      end
      wr <= '0;
      start <= '0;
      fault <= '0;
      fault_q <= '0;
    end else begin
      fault_q <= i_fault;
      fault <= (fault & ~fault_clr) | (i_fault & ~fault_q);
      start <= we_cmd;
      for (int c = 0; c < CHANNELS; c++) begin
        if (we_dev[c]) dev_addr[c] <= strb_merge(dev_addr[c], wr_data, wr_strb);
        if (we_reg[c]) reg_num[c] <= strb_merge(reg_num[c], wr_data, wr_strb);
        if (we_tx[c]) tx_data[c] <= strb_merge(tx_data[c], wr_data, wr_strb);
        if (we_cmd[c]) begin
          len[c] <= cmd_len;
          wr[c] <= wr_data[CMD_WR_BIT];
        end
      end
    end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_out
    assign o_dev_addr[7*i +: 7] = dev_addr[i][6:0];
    assign o_reg_num[8*i +: 8] = reg_num[i][7:0];
    assign o_tx_data[32*i +: 32] = tx_data[i];
    assign o_len[3*i +: 3] = len[i];
  end
  assign o_wr = wr;
  assign o_start = start;
endmodule

// File: tb/tb_i2c_register_mc.sv
// tb_i2c_register_mc: scoreboard bench for the multi-channel I2C register block
module tb_i2c_register_mc;
  logic clk, resetn;
  logic [27:0] o_dev_addr;
  logic [31:0] o_reg_num;
  logic [11:0] o_len;
  logic [3:0] o_wr, o_start, i_idle, i_fault;
  logic [127:0] o_tx_data, i_rx_data;
  logic [31:0] i_module_rev;
  int n_checks = 0;
  int n_errors = 0;
  int start_cnt [4];
  int exp_start [4];
  int dbl = 0;
  logic [3:0] start_prev = '0;
  logic [1:0] wq [$];
  logic [33:0] rq [$];
  i2c_register_mc_if axi ();
  i2c_register_mc #(.CHANNELS(4), .MAX_LEN(4), .ADDR_MASK(7'h7F)) dut (
    .clk(clk),
    .resetn(resetn),
    .s_axi(axi),
    .o_dev_addr(o_dev_addr),
    .o_reg_num(o_reg_num),
    .o_len(o_len),
    .o_wr(o_wr),
    .o_tx_data(o_tx_data),
    .o_start(o_start),
    .i_idle(i_idle),
    .i_fault(i_fault),
    .i_rx_data(i_rx_data),
    .i_module_rev(i_module_rev)
  );
  always #5 clk = ~clk;
  // Count launch strobes per channel and flag back-to-back strobes.
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) start_cnt[c] += int'(o_start[c]);
    if (|(o_start & start_prev)) dbl++;
    start_prev = o_start;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_starts();
    for (int c = 0; c < 4; c++) check($sformatf("start%0d", c), 32'(start_cnt[c]), 32'(exp_start[c]));
  endtask
  task automatic axi_write(input logic [4:0] idx, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] er, input int w_lead = 0, input int b_hold = 0);
    int t;
    logic awh, wh;
    logic [1:0] e;
    wq.push_back(er);
    @(negedge clk);
    axi.awaddr = {25'b0, idx, 2'b0};
    axi.wdata = d;
    axi.wstrb = s;
    axi.wvalid = 1'b1;
    axi.awvalid = (w_lead == 0);
    axi.bready = (b_hold == 0);
    t = 0;
    while ((axi.awvalid || axi.wvalid || t < w_lead) && t < 40) begin
      awh = axi.awvalid && axi.awready;
      wh = axi.wvalid && axi.wready;
      @(negedge clk);
      t++;
      if (awh) axi.awvalid = 1'b0;
      if (wh) axi.wvalid = 1'b0;
      if (t == w_lead) axi.awvalid = 1'b1;
    end
    while (!axi.bvalid && t < 40) begin
      @(negedge clk);
      t++;
    end
    e = wq.pop_front();
    if (!axi.bvalid) check($sformatf("b_timeout%0d", idx), 32'd0, 32'd1);
    else begin
      for (int k = 0; k < b_hold; k++) begin
        check("bvalid_hold", 32'(axi.bvalid), 32'd1);
        check("bresp_hold", 32'(axi.bresp), 32'(e));
        check("aw_w_blocked", 32'({axi.awready, axi.wready}), 32'd0);
        @(negedge clk);
      end
      axi.bready = 1'b1;
      check($sformatf("bresp%0d", idx), 32'(axi.bresp), 32'(e));
      @(negedge clk);
    end
    axi.bready = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid = 1'b0;
  endtask
  task automatic axi_read(input logic [4:0] idx, input logic [31:0] ed, input logic [1:0] er);
    int t;
    logic hs;
    logic [33:0] e;
    rq.push_back({er, ed});
    @(negedge clk);
    axi.araddr = {25'b0, idx, 2'b0};
    axi.arvalid = 1'b1;
    axi.rready = 1'b1;
    t = 0;
    while (axi.arvalid && t < 40) begin
      hs = axi.arready;
      @(negedge clk);
      t++;
      if (hs) axi.arvalid = 1'b0;
    end
    while (!axi.rvalid && t < 40) begin
      @(negedge clk);
      t++;
    end
    e = rq.pop_front();
    if (!axi.rvalid) check($sformatf("r_timeout%0d", idx), 32'd0, 32'd1);
    else begin
      check($sformatf("rdata%0d", idx), axi.rdata, e[31:0]);
      check($sformatf("rresp%0d", idx), 32'(axi.rresp), 32'(e[33:32]));
      @(negedge clk);
    end
    axi.rready = 1'b0;
    axi.arvalid = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    clk = 1'b0;
    resetn = 1'b1;
    axi.awvalid = 1'b0;
    axi.wvalid = 1'b0;
    axi.bready = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready = 1'b0;
    axi.awaddr = '0;
    axi.araddr = '0;
    axi.wdata = '0;
    axi.wstrb = '0;
    i_idle = 4'hF;
    i_fault = 4'h0;
    i_module_rev = 32'h0001_0002;
    i_rx_data = {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};
    #2 resetn = 1'b0;
    #10;
    check("rst_ready", 32'({axi.awready, axi.wready, axi.arready}), 32'd0);
    check("rst_valid", 32'({axi.bvalid, axi.rvalid}), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'({axi.awready, axi.wready, axi.arready}), 32'h7);
    check("rst_start_len", {16'(o_start), 4'(o_wr), o_len}, 32'd0);
    axi_read(5'd4, 32'd0, 2'd0);
    axi_read(5'd5, 32'd0, 2'd0);
    axi_read(5'd6, 32'd0, 2'd0);
    axi_read(5'd0, 32'h0001_0002, 2'd0);
    axi_write(5'd14, 32'h50, 4'hF, 2'd0);
    axi_write(5'd17, 32'h13, 4'hF, 2'd0);
    exp_start[2]++;
    repeat (2) @(negedge clk);
    check_starts();
    check("ch2_wr", 32'(o_wr[2]), 32'd1);
    check("ch2_len", 32'(o_len[8:6]), 32'd3);
    check("ch2_dev", 32'(o_dev_addr[20:14]), 32'h50);
    axi_read(5'd17, 32'd0, 2'd0);
    axi_read(5'd18, 32'hC2C2_0002, 2'd0);
    axi_write(5'd10, 32'h11, 4'hF, 2'd0);
    i_idle[1] = 1'b0;
    axi_write(5'd10, 32'h22, 4'hF, 2'd2);
    axi_read(5'd10, 32'h11, 2'd0);
    axi_write(5'd12, 32'h11, 4'hF, 2'd2);
    axi_read(5'd1, 32'hD, 2'd0);
    i_idle[1] = 1'b1;
    axi_write(5'd7, 32'h10, 4'hF, 2'd2);
    axi_write(5'd7, 32'h05, 4'hF, 2'd2);
    axi_write(5'd7, 32'h13, 4'hE, 2'd0);
    axi_write(5'd7, 32'h04, 4'hF, 2'd0);
    exp_start[0]++;
    repeat (2) @(negedge clk);
    check_starts();
    check("ch0_len", 32'(o_len[2:0]), 32'd4);
    check("ch0_wr", 32'(o_wr[0]), 32'd0);
    @(negedge clk);
    i_fault[3] = 1'b1;
    @(negedge clk);
    i_fault[3] = 1'b0;
    axi_read(5'd2, 32'h8, 2'd0);
    fork
      begin
        @(negedge clk);
        @(negedge clk);
        i_fault[0] = 1'b1;
      end
    join_none
    axi_write(5'd2, 32'h9, 4'hF, 2'd0);
    axi_read(5'd2, 32'h1, 2'd0);
    i_fault[0] = 1'b0;
    axi_write(5'd2, 32'h1, 4'h2, 2'd0);
    axi_read(5'd2, 32'h1, 2'd0);
    axi_write(5'd2, 32'h1, 4'h1, 2'd0);
    axi_read(5'd2, 32'h0, 2'd0);
    axi_write(5'd21, 32'h1234_5678, 4'hF, 2'd0, 2, 3);
    check("aw_ready_after_b", 32'({axi.awready, axi.wready}), 32'h3);
    axi_read(5'd21, 32'h1234_5678, 2'd0);
    check("o_tx3", o_tx_data[127:96], 32'h1234_5678);
    do_reset();
    check("rst2_len_wr", {16'(o_wr), 4'h0, o_len}, 32'd0);
    axi_read(5'd14, 32'd0, 2'd0);
    axi_write(5'd6, 32'hAABB_CCDD, 4'b0101, 2'd0);
    axi_read(5'd6, 32'h00BB_00DD, 2'd0);
    axi_read(5'd31, 32'd0, 2'd3);
    axi_read(5'd24, 32'd0, 2'd3);
    axi_read(5'd23, 32'hD3D3_0003, 2'd0);
    axi_read(5'd3, 32'd0, 2'd0);
    axi_write(5'd24, 32'h1, 4'hF, 2'd2);
    axi_write(5'd0, 32'h1, 4'hF, 2'd2);
    axi_write(5'd3, 32'h1, 4'hF, 2'd2);
    axi_write(5'd8, 32'h1, 4'hF, 2'd2);
    axi_read(5'd2, 32'd0, 2'd0);
    check_starts();
    check("start_gap", 32'(dbl), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
